// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a power-of-two byte FIFO; frame format and baud
// divisor are latched when each byte is popped and held for its whole frame.
module uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          tx,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    data_size,
  input  logic                          parity_en,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop_bit_size,
  input  logic [7:0]                    data,
  input  logic                          send,
  output logic                          ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_d;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, push, pop;
  logic [DIV_W-1:0] cnt, cnt_d, div_r;
  logic [2:0]       bit_idx, bit_idx_d, last_idx;
  logic             stop_idx, stop_idx_d;
  logic [7:0]       frame, par_mask;
  logic [1:0]       size_r, mode_r;
  logic             par_en_r, stop2_r;
  logic             par_bit, tx_d, bit_end;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign push       = send && !full;
  assign ready      = !full;
  assign busy       = (state != IDLE) || !empty;
  assign fifo_count = count;
  assign bit_end    = (cnt == '0);
  assign last_idx   = {1'b0, size_r} + 3'd4;
  assign par_mask   = 8'hFF >> (2'd3 - size_r);

  always_comb begin
    par_bit = 1'b0;
    case (mode_r)
      2'b11:   par_bit = ~^(frame & par_mask);
      2'b10:   par_bit = ^(frame & par_mask);
      2'b01:   par_bit = 1'b1;
      default: par_bit = 1'b0;
    endcase
  end

  // Every bit boundary reloads the down-counter; a pop reloads from the live
  // baud_div because div_r only captures it on that same edge.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    bit_idx_d  = bit_idx;
    stop_idx_d = stop_idx;
    pop        = 1'b0;
    if (state != IDLE && !bit_end) cnt_d = cnt - DIV_W'(1);
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
          cnt_d   = baud_div;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
          cnt_d     = div_r;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = div_r;
          if (bit_idx == last_idx) begin
            state_d    = par_en_r ? PARITY : STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
          cnt_d      = div_r;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_r && !stop_idx) begin
            stop_idx_d = 1'b1;
            cnt_d      = div_r;
          end else if (!empty) begin
            pop     = 1'b1;
            state_d = START;
            cnt_d   = baud_div;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = frame[bit_idx_d];
      PARITY:  tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_d;
      tx       <= tx_d;
      cnt      <= cnt_d;
      bit_idx  <= bit_idx_d;
      stop_idx <= stop_idx_d;
      overflow <= send && full;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= data;
    if (!rst && pop) begin
      frame    <= mem[rd_ptr];
      div_r    <= baud_div;
      size_r   <= data_size;
      par_en_r <= parity_en;
      mode_r   <= parity_mode;
      stop2_r  <= stop_bit_size;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus randomized batches, checked
// every cycle against a per-cycle line timeline built from frame rules.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 16;

  logic          clk;
  logic          rst;
  logic          tx;
  logic [DW-1:0] baud_div;
  logic [1:0]    data_size;
  logic          parity_en;
  logic [1:0]    parity_mode;
  logic          stop_bit_size;
  logic [7:0]    data;
  logic          send;
  logic          ready;
  logic          busy;
  logic [2:0]    fifo_count;
  logic          overflow;

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
    .clk(clk), .rst(rst), .tx(tx), .baud_div(baud_div), .data_size(data_size),
    .parity_en(parity_en), .parity_mode(parity_mode), .stop_bit_size(stop_bit_size),
    .data(data), .send(send), .ready(ready), .busy(busy), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [7:0]  mq[$];
  bit          exp_line[$];
  logic [255:0] cap;
  int          cap_n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) begin
      passed = passed + 1;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expands one byte into its line waveform, one entry per clock cycle.
  function automatic void build_frame(input logic [7:0] d);
    int n    = 5 + int'(data_size);
    int ones = 0;
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (parity_en) begin
      case (parity_mode)
        2'b11:   bits.push_back((ones % 2) == 0);
        2'b10:   bits.push_back((ones % 2) == 1);
        2'b01:   bits.push_back(1'b1);
        default: bits.push_back(1'b0);
      endcase
    end
    bits.push_back(1'b1);
    if (stop_bit_size) bits.push_back(1'b1);
    foreach (bits[k]) repeat (int'(baud_div) + 1) exp_line.push_back(bits[k]);
  endfunction

  task automatic step();
    bit acc, act, e, exp_ovf;
    int pre_size;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      exp_line.delete();
      exp_ovf = 1'b0;
      act     = 1'b0;
    end else begin
      pre_size = mq.size();
      acc      = send && (pre_size < int'(DEPTH));
      exp_ovf  = send && !acc;
      if (exp_line.size() == 0 && pre_size > 0) build_frame(mq.pop_front());
      if (acc) mq.push_back(data);
      act = exp_line.size() > 0;
    end
    e = act ? exp_line.pop_front() : 1'b1;
    check("tx", 32'(tx), 32'(e));
    check("busy", 32'(busy), 32'(act || mq.size() > 0));
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("ready", 32'(ready), 32'(mq.size() < int'(DEPTH)));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    if (cap_n < 256) cap[cap_n] = tx;
    cap_n++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_byte(input logic [7:0] d);
    data = d;
    send = 1'b1;
    step();
    send  = 1'b0;
    cap_n = 0;
  endtask

  task automatic drain();
    for (int g = 0; g < 3000 && (exp_line.size() > 0 || mq.size() > 0); g++) step();
    step();
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic set_cfg(input int div, input logic [1:0] sz, input logic pe,
                         input logic [1:0] pm, input logic s2);
    baud_div      = DW'(div);
    data_size     = sz;
    parity_en     = pe;
    parity_mode   = pm;
    stop_bit_size = s2;
  endtask

  initial begin
    rst  = 1'b1;
    send = 1'b0;
    data = 8'h00;
    set_cfg(3, 2'b11, 1'b0, 2'b00, 1'b0);
    run(2);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_count", 32'(fifo_count), 32'd0);
    rst = 1'b0;
    run(3);

    // 8N1, divisor 3, single 0x55
    send_byte(8'h55);
    run(40);
    begin
      logic [9:0] pat;
      bit ok;
      pat = {1'b1, 8'h55, 1'b0};
      ok  = 1'b1;
      for (int i = 0; i < 40; i++) if (cap[i] !== pat[i/4]) ok = 1'b0;
      check("frame_8n1_0x55", 32'(ok), 32'd1);
    end
    step();
    check("busy_after_8n1", 32'(busy), 32'd0);
    run(3);

    // 7 bits, even parity, two stops, divisor 0
    set_cfg(0, 2'b10, 1'b1, 2'b10, 1'b1);
    send_byte(8'hFF);
    run(11);
    check("frame_7e2_0xff", 32'(cap[10:0]), 32'h7FE);
    run(3);

    // 5-bit parity modes on 0x03
    set_cfg(0, 2'b00, 1'b1, 2'b11, 1'b0);
    send_byte(8'h03);
    run(10);
    check("parity_odd", 32'(cap[6]), 32'd1);
    parity_mode = 2'b01;
    send_byte(8'h03);
    run(10);
    check("parity_mark", 32'(cap[6]), 32'd1);
    parity_mode = 2'b00;
    send_byte(8'h03);
    run(10);
    check("parity_space", 32'(cap[6]), 32'd0);

    // FIFO fill and overflow, divisor 9
    set_cfg(9, 2'b11, 1'b0, 2'b00, 1'b0);
    send = 1'b1;
    for (int k = 0; k < 6; k++) begin
      data = 8'(8'hA0 + k);
      step();
      if (k == 4) check("ready_low_full", 32'(ready), 32'd0);
      if (k == 5) begin
        check("overflow_pulse", 32'(overflow), 32'd1);
        check("count_full", 32'(fifo_count), 32'd4);
      end
    end
    send = 1'b0;
    step();
    check("overflow_one_cycle", 32'(overflow), 32'd0);
    drain();

    // Divisor change mid-frame only affects the next frame
    set_cfg(3, 2'b11, 1'b0, 2'b00, 1'b0);
    send_byte(8'h3D);
    data = 8'h01;
    send = 1'b1;
    step();
    send = 1'b0;
    run(9);
    baud_div = DW'(7);
    drain();
    check("divchg_first_frame", 32'(cap[4:0]), 32'h10);
    check("divchg_second_start", 32'(cap[55:40]), 32'hFF00);

    // Reset during DATA with three bytes queued
    set_cfg(3, 2'b11, 1'b0, 2'b00, 1'b0);
    send = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data = 8'(8'h11 * (k + 1));
      step();
    end
    send = 1'b0;
    run(6);
    rst  = 1'b1;
    send = 1'b1;
    step();
    check("rst_mid_tx", 32'(tx), 32'd1);
    check("rst_mid_count", 32'(fifo_count), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    rst  = 1'b0;
    send = 1'b0;
    run(60);

    // Randomized batches
    for (int b = 0; b < 20; b++) begin
      set_cfg(int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
        data = 8'($urandom);
        send = 1'b1;
        step();
        send = 1'b0;
        run(int'($urandom_range(0, 3)));
      end
      drain();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
